// File: rtl/hms_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hms_clock_ctrl
// Brief   : 24-hour H:M:S timekeeper with debounced mode/field/increment
//           buttons and a decimal-point mask marking the field being edited.
// Revision: 1.0 - initial release
// ============================================================================
module hms_clock_ctrl #(
    parameter int P_TICK_DIV = 50000000,
    parameter int P_DEBOUNCE = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw_mode,
    input  logic       i_sw_pos,
    input  logic       i_sw_incr,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_mode,
    output logic [1:0] o_pos,
    output logic [5:0] o_six_dp
);

    localparam int c_TICK_W = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;
    localparam int c_DB_W   = (P_DEBOUNCE > 1) ? $clog2(P_DEBOUNCE) : 1;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    state_t              r_state;
    logic [5:0]          r_sec;
    logic [5:0]          r_min;
    logic [4:0]          r_hour;
    logic [1:0]          r_pos;
    logic [5:0]          r_dp;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;
    logic [2:0]          w_raw;
    logic [2:0]          w_press;
    logic [1:0]          w_pos_nxt;
    logic [5:0]          w_dp_nxt;

    assign w_raw = {i_sw_incr, i_sw_pos, i_sw_mode};

    // Buttons idle high; the debounce counter only runs while the synchronized
    // level disagrees with the accepted one, so any return to it restarts it.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic              r_s1;
            logic              r_s2;
            logic              r_stable;
            logic              r_press;
            logic [c_DB_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1     <= 1'b1;
                    r_s2     <= 1'b1;
                    r_stable <= 1'b1;
                    r_press  <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_s1    <= w_raw[gi];
                    r_s2    <= r_s1;
                    r_press <= 1'b0;
                    if (r_s2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_W'(P_DEBOUNCE - 1)) begin
                        r_stable <= r_s2;
                        r_cnt    <= '0;
                        r_press  <= ~r_s2;
                    end else begin
                        r_cnt <= r_cnt + c_DB_W'(1);
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    assign w_tick = (r_state == ST_RUN) && (r_tick_cnt == c_TICK_W'(P_TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (r_state == ST_SET || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
        end
    end

    assign w_pos_nxt = (r_pos == 2'd2) ? 2'd0 : r_pos + 2'd1;

    always_comb begin
        w_dp_nxt = 6'b000000;
        case (w_pos_nxt)
            2'd0:    w_dp_nxt = 6'b000011;
            2'd1:    w_dp_nxt = 6'b001100;
            default: w_dp_nxt = 6'b110000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_sec   <= '0;
            r_min   <= '0;
            r_hour  <= '0;
            r_pos   <= '0;
            r_dp    <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // A tick coinciding with a mode press still counts.
                    if (w_tick) begin
                        if (r_sec == 6'd59) begin
                            r_sec <= '0;
                            if (r_min == 6'd59) begin
                                r_min  <= '0;
                                r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                            end else begin
                                r_min <= r_min + 6'd1;
                            end
                        end else begin
                            r_sec <= r_sec + 6'd1;
                        end
                    end
                    if (w_press[0]) begin
                        r_state <= ST_SET;
                        r_pos   <= 2'd0;
                        r_dp    <= 6'b000011;
                    end
                end
                default: begin
                    if (w_press[0]) begin
                        r_state <= ST_RUN;
                        r_pos   <= 2'd0;
                        r_dp    <= 6'b000000;
                    end else if (w_press[1]) begin
                        r_pos <= w_pos_nxt;
                        r_dp  <= w_dp_nxt;
                    end else if (w_press[2]) begin
                        case (r_pos)
                            2'd0:    r_sec  <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
                            2'd1:    r_min  <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                            default: r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                        endcase
                    end
                end
            endcase
        end
    end

    assign o_sec    = r_sec;
    assign o_min    = r_min;
    assign o_hour   = r_hour;
    assign o_mode   = (r_state == ST_SET);
    assign o_pos    = r_pos;
    assign o_six_dp = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_hms_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hms_clock_ctrl
// Brief   : Randomized self-checking bench for hms_clock_ctrl against a
//           seconds-of-day / sliding-window behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hms_clock_ctrl;

    localparam int P_TICK_DIV = 10;
    localparam int P_DEBOUNCE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_mode;
    logic       sw_pos;
    logic       sw_incr;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_mode;
    logic [1:0] o_pos;
    logic [5:0] o_six_dp;

    int n_cmp = 0;
    int n_err = 0;

    // Model: time as seconds of day, buttons as a window of raw samples.
    int m_t;
    bit m_set;
    int m_pos;
    int m_cyc;
    int m_run_start;
    bit m_stable[3];
    bit m_evt[3];
    bit m_hist[3][P_DEBOUNCE+2];

    hms_clock_ctrl #(
        .P_TICK_DIV(P_TICK_DIV),
        .P_DEBOUNCE(P_DEBOUNCE)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sw_mode(sw_mode),
        .i_sw_pos (sw_pos),
        .i_sw_incr(sw_incr),
        .o_sec    (o_sec),
        .o_min    (o_min),
        .o_hour   (o_hour),
        .o_mode   (o_mode),
        .o_pos    (o_pos),
        .o_six_dp (o_six_dp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_set = 0; m_pos = 0; m_cyc = 0; m_run_start = 1;
        for (int b = 0; b < 3; b++) begin
            m_stable[b] = 1'b1;
            m_evt[b]    = 1'b0;
            for (int i = 0; i < P_DEBOUNCE + 2; i++) m_hist[b][i] = 1'b1;
        end
    endtask

    task automatic bump_field(input int f);
        int s, mi, h;
        s = m_t % 60; mi = (m_t / 60) % 60; h = m_t / 3600;
        if (f == 0) s = (s + 1) % 60;
        else if (f == 1) mi = (mi + 1) % 60;
        else h = (h + 1) % 24;
        m_t = h * 3600 + mi * 60 + s;
    endtask

    task automatic model_edge();
        bit raw[3];
        bit tick;
        bit all_diff;
        raw[0] = sw_mode; raw[1] = sw_pos; raw[2] = sw_incr;
        m_cyc++;
        tick = !m_set && ((m_cyc - m_run_start) % P_TICK_DIV == P_TICK_DIV - 1);
        if (m_evt[0]) begin
            if (!m_set) begin
                if (tick) m_t = (m_t + 1) % 86400;
                m_set = 1; m_pos = 0;
            end else begin
                m_set = 0; m_pos = 0; m_run_start = m_cyc + 1;
            end
        end else if (!m_set) begin
            if (tick) m_t = (m_t + 1) % 86400;
        end else if (m_evt[1]) begin
            m_pos = (m_pos + 1) % 3;
        end else if (m_evt[2]) begin
            bump_field(m_pos);
        end
        // Level is accepted once the last P synchronized samples all disagree.
        for (int b = 0; b < 3; b++) begin
            for (int i = P_DEBOUNCE + 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
            m_hist[b][0] = raw[b];
            all_diff = 1'b1;
            for (int i = 2; i < P_DEBOUNCE + 2; i++)
                if (m_hist[b][i] == m_stable[b]) all_diff = 1'b0;
            m_evt[b] = all_diff && m_stable[b];
            if (all_diff) m_stable[b] = !m_stable[b];
        end
    endtask

    task automatic check_all();
        check_eq("sec",  o_sec,    m_t % 60);
        check_eq("min",  o_min,    (m_t / 60) % 60);
        check_eq("hour", o_hour,   m_t / 3600);
        check_eq("mode", o_mode,   m_set);
        check_eq("pos",  o_pos,    m_pos);
        check_eq("dp",   o_six_dp, m_set ? (3 << (2 * m_pos)) : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_btn(input int b, input bit v);
        if (b == 0) sw_mode = v;
        else if (b == 1) sw_pos = v;
        else sw_incr = v;
    endtask

    task automatic press(input int b);
        if ($urandom_range(0, 1) == 1) begin
            set_btn(b, 1'b0);
            repeat ($urandom_range(1, P_DEBOUNCE - 1)) cycle();
            set_btn(b, 1'b1);
            repeat ($urandom_range(1, 3)) cycle();
        end
        set_btn(b, 1'b0);
        repeat ($urandom_range(P_DEBOUNCE + 3, P_DEBOUNCE + 6)) cycle();
        set_btn(b, 1'b1);
        repeat ($urandom_range(P_DEBOUNCE + 3, P_DEBOUNCE + 6)) cycle();
    endtask

    // Enters SET from RUN, dials in h:m:s and leaves the cursor on seconds.
    task automatic set_time(input int h, input int mi, input int s);
        int n;
        press(0);
        n = (s - m_t % 60 + 60) % 60;
        repeat (n) press(2);
        press(1);
        n = (mi - (m_t / 60) % 60 + 60) % 60;
        repeat (n) press(2);
        press(1);
        n = (h - m_t / 3600 + 24) % 24;
        repeat (n) press(2);
        press(1);
    endtask

    initial begin
        int k;
        int s0;
        int mn0;
        rst_n = 1'b0; sw_mode = 1'b1; sw_pos = 1'b1; sw_incr = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Free run: one minute of ticks.
        repeat (600) cycle();
        check_eq("run600_min", o_min, 1);
        check_eq("run600_sec", o_sec, 0);

        // Increment is ignored outside SET.
        press(2);

        // Full-day rollover in a single update.
        set_time(23, 59, 58);
        press(0);
        for (k = 0; k < 40 && o_sec != 0; k++) cycle();
        check_eq("roll_sec", o_sec, 0);
        check_eq("roll_min", o_min, 0);
        check_eq("roll_hour", o_hour, 0);

        // Short bounces are rejected, a held press yields one event.
        repeat (5) begin
            sw_mode = 1'b0; repeat (3) cycle();
            sw_mode = 1'b1; repeat (3) cycle();
        end
        check_eq("bounce_mode", o_mode, 0);
        sw_mode = 1'b0;
        repeat (6) cycle();
        check_eq("db_lat6", o_mode, 0);
        cycle();
        check_eq("db_lat7", o_mode, 1);
        repeat (3) cycle();
        sw_mode = 1'b1;
        repeat (12) cycle();
        check_eq("db_single", o_mode, 1);
        press(0);

        // Set flow, hour wrap, and exit-to-first-tick spacing.
        set_time(12, 34, 56);
        press(1);
        press(1);
        check_eq("flow_pos", o_pos, 2);
        check_eq("flow_dp", o_six_dp, 6'b110000);
        repeat (12) press(2);
        check_eq("flow_hour", o_hour, 0);
        check_eq("flow_min", o_min, 34);
        check_eq("flow_sec", o_sec, 56);
        sw_mode = 1'b0;
        for (k = 0; k < 20 && o_mode != 0; k++) cycle();
        check_eq("exit_mode", o_mode, 0);
        sw_mode = 1'b1;
        s0 = o_sec;
        repeat (9) cycle();
        check_eq("exit_hold", o_sec, s0);
        cycle();
        check_eq("exit_tick", o_sec, (s0 + 1) % 60);

        // Field wrap without carry.
        press(0);
        repeat ((59 - m_t % 60 + 60) % 60) press(2);
        check_eq("wrap_pre", o_sec, 59);
        mn0 = o_min;
        press(2);
        check_eq("wrap_sec", o_sec, 0);
        check_eq("wrap_min", o_min, mn0);
        press(0);

        // Mode and pos in the same cycle: mode wins, pos event dropped.
        sw_mode = 1'b0; sw_pos = 1'b0;
        repeat (8) cycle();
        sw_mode = 1'b1; sw_pos = 1'b1;
        repeat (8) cycle();
        check_eq("simul_mode", o_mode, 1);
        check_eq("simul_pos", o_pos, 0);

        // Asynchronous reset mid-SET and mid-debounce.
        press(1);
        sw_incr = 1'b0;
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        sw_incr = 1'b1;
        #1;
        check_eq("arst_sec", o_sec, 0);
        check_eq("arst_min", o_min, 0);
        check_eq("arst_hour", o_hour, 0);
        check_eq("arst_mode", o_mode, 0);
        check_eq("arst_pos", o_pos, 0);
        check_eq("arst_dp", o_six_dp, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) cycle();

        // Random button activity.
        repeat (400) begin
            k = $urandom_range(0, 7);
            sw_mode = !k[0];
            sw_pos  = !k[1];
            sw_incr = !k[2];
            repeat ($urandom_range(1, 12)) cycle();
        end
        sw_mode = 1'b1; sw_pos = 1'b1; sw_incr = 1'b1;
        repeat (20) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hms_clock_ctrl.md
# hms_clock_ctrl

Timekeeping and time-set controller that sits directly upstream of the display path. It generates a 1 s tick from clk and runs a 24-hour hours/minutes/seconds counter. Three raw push buttons let the user stop the clock and set each field. Binary seconds, minutes and hours go out to per-field double_fig_sep/fnd_dec instances, and a 6-bit decimal-point vector goes to led_disp to mark the field being edited.

## Interface
Parameters:
- P_TICK_DIV, default 50000000: clk cycles per 1 s tick (50 MHz clock).
- P_DEBOUNCE, default 500000: consecutive stable cycles needed to accept a button level change (10 ms).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_sw_mode  input  1  raw mode button, active-low, asynchronous to clk.
- i_sw_pos  input  1  raw field-select button, active-low, asynchronous.
- i_sw_incr  input  1  raw increment button, active-low, asynchronous.
- o_sec  output  6  seconds, 0..59.
- o_min  output  6  minutes, 0..59.
- o_hour  output  5  hours, 0..23.
- o_mode  output  1  0 = RUN, 1 = SET.
- o_pos  output  2  selected field in SET: 0 = sec, 1 = min, 2 = hour. Value 3 never occurs.
- o_six_dp  output  6  dp request, 1 = lit. Bits [1:0] = sec digits, [3:2] = min, [5:4] = hour.

## Operation
Button front end (identical per button):
- 2-FF synchronizer, reset value 1.
- Debouncer holds a stable level, reset value 1. A per-button counter counts cycles where the synchronized level differs from the stable level.
- Counter clears whenever the synchronized level equals the stable level. At count P_DEBOUNCE the stable level flips and the counter clears.
- Press event: one-cycle pulse on a stable 1->0 transition. Releases generate no event.
- Holding a button generates exactly one event.

Tick generator:
- Counter runs 0..P_TICK_DIV-1 in RUN only. The tick pulse is asserted in the cycle the counter wraps from P_TICK_DIV-1 to 0.
- In SET the counter is forced to 0 and no ticks occur.

Time counter:
- On a tick: sec+1.
- sec 59 -> 0 with min+1. min 59 -> 0 with hour+1. hour 23 -> 0.
- All carries resolve in the same cycle, so 23:59:59 -> 00:00:00 in a single update.

Mode state machine (RUN, SET):
- RUN --mode event--> SET. On entry pos = 0 and the time freezes at its current value.
- SET --mode event--> RUN. The tick counter restarts from 0, so the first tick comes P_TICK_DIV cycles after the exit.
- pos event in SET: pos 0 -> 1 -> 2 -> 0. Ignored in RUN.
- incr event in SET: the selected field +1 and wraps at its own limit (sec/min 59 -> 0, hour 23 -> 0), with no carry into other fields. Ignored in RUN.

Same-cycle events:
- Priority mode > pos > incr. Lower-priority events in that cycle are discarded, not queued.
- A tick and a mode event in the same cycle: the tick is applied and the mode switches to SET.

DP output:
- RUN: o_six_dp = 0.
- SET: the two bits of the selected field are 1 and all others 0 (e.g. pos 1 -> 6'b001100).

## Timing
- All outputs registered. Reset values: o_sec = 0, o_min = 0, o_hour = 0, o_mode = 0, o_pos = 0, o_six_dp = 0. Tick and debounce counters are 0.
- Button latency: a raw level change held steady reaches the event pulse after 2 (sync) + P_DEBOUNCE cycles. The field, mode or pos output updates on the clock edge after the event, so total latency is 3 + P_DEBOUNCE cycles.
- Tick to time outputs: o_sec/o_min/o_hour update on the edge ending the tick cycle (latency 1).
- o_six_dp is combinational from registered o_mode/o_pos, or registered in parallel with them. Either way it is valid in the same cycle as o_mode/o_pos.
- A bounce shorter than P_DEBOUNCE cycles produces no event and no output change.
- Asserting rst_n mid-operation (including during SET or mid-debounce) immediately returns every register to its reset value. Operation resumes in RUN from 00:00:00.

## Test plan
All scenarios use P_TICK_DIV = 10 and P_DEBOUNCE = 4.
- Reset/run: release reset and run 600 cycles -> o_sec reaches 59 at cycle ~590, then 0 with o_min = 1. o_mode = 0 and o_six_dp = 0 throughout.
- Full rollover: advance to 23:59:58, then apply 2 ticks -> 23:59:59, then 00:00:00 in one update.
- Debounce: pulse i_sw_mode low for 3 cycles, repeatedly -> no change. Hold it low for 10 cycles -> o_mode = 1 exactly 7 cycles after the falling edge, and a single event only.
- Set flow: from 12:34:56 enter SET, press pos twice (o_pos = 2, o_six_dp = 6'b110000), then press incr 12 times -> hour wraps to 0 and min/sec stay 34/56. Exit SET -> next sec increment occurs exactly 10 cycles later.
- Field wrap without carry: SET, pos 0, sec = 59, incr -> sec = 0 and min unchanged. Incr in RUN -> no change.
- Simultaneous events and reset: mode and pos events in the same cycle while in RUN -> o_mode = 1 and o_pos = 0. Assert rst_n mid-SET -> all outputs return to 0 asynchronously.
